// File: rtl/fetch_unit_pkg.sv
// Shared RV32I front-end definitions: opcode constants, NOP encoding, fetch FSM
// states and a word-alignment helper. Imported by fetch_unit, rv32i_pc_reg and
// the Controller so every stage agrees on the encodings.
package fetch_unit_pkg;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_pc_reg.sv
// Program counter register: reset to RESET_PC, +4 increment, aligned redirect load.
// Latency: new PC visible the cycle after load_i/inc_i; pc_nxt_o shows it early.
// Backpressure: none; load_i has priority over inc_i.
// Ports: clk, rst_n (sync, active-low), load_i/load_pc_i (redirect target),
//        inc_i (advance by one word), pc_o (current), pc_nxt_o (next-state value).
module rv32i_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_nxt_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(load_pc_i);
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;  // 0xFFFF_FFFC wraps to 0 naturally
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_nxt_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one word per request, holds it for the decode stage.
// Latency: 1 cycle from imem_ack to instr_valid; request issued the cycle after IDLE/consume.
// Backpressure: instr_ready=0 holds the instruction and stops fetching; redirects always win.
// Ports: clk, rst_n (sync, active-low); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        redirect/redirect_pc branch target; instr_valid/instr_ready/instr/pc_out and the
//        decoded fields opcode/rd/funct3/rs1/rs2/funct7 toward the Controller/ALU stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] pc_out
);

  fetch_state_e state_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_out_q;

  logic [31:0]  pc_q;
  logic [31:0]  pc_nxt;
  logic         pc_inc;

  // Redirect is honoured in every state; the PC only advances when the held
  // instruction is consumed.
  assign pc_inc = (state_q == ST_HOLD) && instr_ready;

  rv32i_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc_q),
    .pc_nxt_o  (pc_nxt)
  );

  // imem_addr is registered separately from the PC: in DRAIN the PC already
  // holds the redirect target while the bus must keep showing the old address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_FETCH;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_nxt;
        end

        ST_FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              // Response belongs to the abandoned path; refetch immediately.
              imem_addr_q <= pc_nxt;
            end else begin
              // Request cannot be aborted; wait out its ack on the old address.
              state_q <= ST_DRAIN;
            end
          end else if (imem_ack) begin
            state_q       <= ST_HOLD;
            imem_req_q    <= 1'b0;
            instr_q       <= imem_rdata;
            pc_out_q      <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redirect || instr_ready) begin
            state_q       <= ST_FETCH;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= pc_nxt;
            instr_valid_q <= 1'b0;
          end
        end

        ST_DRAIN: begin
          // Further redirects here only update the PC register.
          if (imem_ack) begin
            state_q     <= ST_FETCH;
            imem_addr_q <= pc_nxt;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;

  // Decode fields come from the held register so they stay stable under backpressure.
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC) share stimulus and
// are compared every cycle against a transaction-level model, after directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } obs_t;

  logic        d0_req, d1_req, d0_vld, d1_vld;
  logic [31:0] d0_addr, d1_addr, d0_instr, d1_instr, d0_pcout, d1_pcout;
  logic [6:0]  d0_opc, d1_opc, d0_f7, d1_f7;
  logic [4:0]  d0_rd, d1_rd, d0_rs1, d1_rs1, d0_rs2, d1_rs2;
  logic [2:0]  d0_f3, d1_f3;
  obs_t        obs0, obs1;

  assign obs0 = {d0_req, d0_addr, d0_vld, d0_instr, d0_pcout, d0_opc, d0_rd, d0_f3, d0_rs1, d0_rs2, d0_f7};
  assign obs1 = {d1_req, d1_addr, d1_vld, d1_instr, d1_pcout, d1_opc, d1_rd, d1_f3, d1_rs1, d1_rs2, d1_f7};

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .imem_req(d0_req), .imem_addr(d0_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(d0_vld), .instr_ready(instr_ready), .instr(d0_instr), .opcode(d0_opc),
    .rd(d0_rd), .funct3(d0_f3), .rs1(d0_rs1), .rs2(d0_rs2), .funct7(d0_f7), .pc_out(d0_pcout)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .imem_req(d1_req), .imem_addr(d1_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(d1_vld), .instr_ready(instr_ready), .instr(d1_instr), .opcode(d1_opc),
    .rd(d1_rd), .funct3(d1_f3), .rs1(d1_rs1), .rs2(d1_rs2), .funct7(d1_f7), .pc_out(d1_pcout)
  );

  // Transaction-level view: is a read outstanding, will its data be thrown away,
  // is an instruction being offered, and what is the PC of the next fetch.
  typedef struct {
    bit          starting;   // just out of reset, first request not yet issued
    bit          outstanding;
    bit          discard;
    bit          offering;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] word_pc;
    logic [31:0] rst_pc;
  } model_t;

  model_t mdl [2];
  bit     armed = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t step(input model_t m, input logic rst, input logic redir,
                                  input logic [31:0] rpc, input logic ack,
                                  input logic [31:0] rdata, input logic rdy);
    model_t n = m;
    logic [31:0] tgt = rpc & 32'hFFFF_FFFC;
    if (!rst) begin
      n.starting = 1; n.outstanding = 0; n.discard = 0; n.offering = 0;
      n.pc = m.rst_pc; n.word = 32'h0000_0013; n.word_pc = m.rst_pc;
    end else if (m.starting) begin
      n.starting = 0;
      if (redir) n.pc = tgt;
      n.outstanding = 1;
      n.addr = n.pc;
    end else if (m.outstanding) begin
      if (ack && !m.discard && !redir) begin
        n.word = rdata; n.word_pc = m.addr; n.offering = 1; n.outstanding = 0;
      end
      if (redir) begin
        n.pc = tgt;
        if (!ack) n.discard = 1;
      end
      if (ack && n.outstanding) begin
        n.discard = 0;
        n.addr = n.pc;
      end
    end else if (m.offering) begin
      if (redir || rdy) begin
        n.pc = redir ? tgt : m.pc + 32'd4;
        n.offering = 0; n.outstanding = 1; n.addr = n.pc;
      end
    end
    return n;
  endfunction

  task automatic cmp(input int k, input obs_t o, input model_t m);
    string p = $sformatf("d%0d_", k);
    chk({p, "req"},   {31'd0, o.req}, {31'd0, m.outstanding});
    if (m.outstanding) chk({p, "addr"}, o.addr, m.addr);
    chk({p, "valid"}, {31'd0, o.vld}, {31'd0, m.offering});
    chk({p, "instr"}, o.instr, m.word);
    chk({p, "pc_out"}, o.pcout, m.word_pc);
    chk({p, "opcode"}, {25'd0, o.opc}, m.word % 128);
    chk({p, "rd"},     {27'd0, o.rd},  (m.word >> 7) % 32);
    chk({p, "funct3"}, {29'd0, o.f3},  (m.word >> 12) % 8);
    chk({p, "rs1"},    {27'd0, o.rs1}, (m.word >> 15) % 32);
    chk({p, "rs2"},    {27'd0, o.rs2}, (m.word >> 20) % 32);
    chk({p, "funct7"}, {25'd0, o.f7},  m.word >> 25);
  endtask

  // One clock: compare at the falling edge, drive, then advance the model at the rising edge.
  task automatic cyc(input logic rst, input logic redir, input logic [31:0] rpc,
                     input logic ack, input logic [31:0] rdata, input logic rdy);
    @(negedge clk);
    if (armed) begin
      cmp(0, obs0, mdl[0]);
      cmp(1, obs1, mdl[1]);
    end
    rst_n = rst; redirect = redir; redirect_pc = rpc;
    imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
    @(posedge clk);
    mdl[0] = step(mdl[0], rst, redir, rpc, ack, rdata, rdy);
    mdl[1] = step(mdl[1], rst, redir, rpc, ack, rdata, rdy);
    if (!rst) armed = 1'b1;
  endtask

  initial begin
    mdl[0] = '{default: '0};
    mdl[1] = '{default: '0};
    mdl[0].rst_pc = 32'h0000_0000;
    mdl[1].rst_pc = 32'hFFFF_FFFC;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    // Reset, then a zero-latency ack of addi x1, x0, 5.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_req", {31'd0, d0_req}, 32'd0);
    chk("rst_instr", d0_instr, 32'h0000_0013);
    chk("rst_pc_out1", d1_pcout, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0);
    #1;
    chk("first_req", {31'd0, d0_req}, 32'd1);
    chk("first_addr", d0_addr, 32'h0);
    cyc(1, 0, 0, 1, 32'h0050_0093, 0);
    #1;
    chk("lat_valid", {31'd0, d0_vld}, 32'd1);
    chk("lat_opcode", {25'd0, d0_opc}, 32'h13);
    chk("lat_rd", {27'd0, d0_rd}, 32'd1);
    chk("lat_rs1", {27'd0, d0_rs1}, 32'd0);

    // Backpressure for five cycles with stray acks that must be ignored.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 32'hBAD0_0000 + i, 0);
    #1;
    chk("bp_instr", d0_instr, 32'h0050_0093);
    chk("bp_req", {31'd0, d0_req}, 32'd0);
    cyc(1, 0, 0, 0, 0, 1);
    #1;
    chk("next_addr", d0_addr, 32'h4);
    chk("wrap_addr", d1_addr, 32'h0);

    // Redirect in FETCH with the ack three cycles later: old word dropped.
    cyc(1, 1, 32'h103, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 0);
    #1;
    chk("drain_addr", d0_addr, 32'h100);
    chk("drain_valid", {31'd0, d0_vld}, 32'd0);

    // Redirect together with instr_ready in HOLD: target wins over pc+4.
    cyc(1, 0, 0, 1, 32'h0020_8133, 0);
    cyc(1, 1, 32'h40, 0, 0, 1);
    #1;
    chk("hold_redir_addr", d0_addr, 32'h40);

    // Reset during FETCH, then a stray ack while IDLE.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h1234_5678, 0);
    #1;
    chk("stray_valid", {31'd0, d0_vld}, 32'd0);
    chk("stray_instr", d0_instr, 32'h0000_0013);

    // Random traffic, compared cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 9) == 0),
          $urandom(),
          ($urandom_range(0, 2) == 0),
          $urandom(),
          ($urandom_range(0, 1) == 0));
    end
    cyc(1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
